// File: rtl/regfile_sb.sv
// Register file with three combinational read ports, one write port and a
// per-register scoreboard of outstanding writers (pending counters).
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int NREGS    = 12,
    parameter int ADDR_W   = 4,
    parameter int BYPASS   = 1,
    parameter int PEND_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3,
    input  logic              wre,
    input  logic [DATA_W-1:0] wd3,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_ready,
    output logic              busy1,
    output logic              busy2,
    output logic              busy3
);

    localparam int CNT_W = $clog2(PEND_MAX + 1);

    logic [DATA_W-1:0] regs [NREGS];
    logic [CNT_W-1:0]  pend [NREGS];

    logic [ADDR_W-1:0] ra [3];
    logic [DATA_W-1:0] rd [3];
    logic [2:0]        busy;

    logic              wr_hit;
    logic              iss_ok;
    logic [NREGS-1:0]  inc_v;
    logic [NREGS-1:0]  dec_v;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(NREGS);
    endfunction

    // Reservation handshake: a reservation is taken on a rising clk edge where
    // iss_valid && iss_ready. iss_ready is computed from state and the write
    // port only, never from iss_valid, so a requester may sample it first.
    always_comb begin
        iss_ready = 1'b1;
        if (in_range(iss_addr)) begin
            iss_ready = (32'(pend[iss_addr]) < 32'(PEND_MAX)) ||
                        (wre && (a3 == iss_addr));
        end
    end

    assign wr_hit = wre && in_range(a3);
    assign iss_ok = iss_valid && iss_ready && in_range(iss_addr);

    // A reservation and a write to the same register cancel each other out.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int i = 0; i < NREGS; i++) begin
            inc_v[i] = iss_ok && (iss_addr == ADDR_W'(i)) &&
                       !(wr_hit && (a3 == ADDR_W'(i)));
            dec_v[i] = wr_hit && (a3 == ADDR_W'(i)) && (pend[i] != '0) &&
                       !(iss_ok && (iss_addr == ADDR_W'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= DATA_W'(i + 1);
                pend[i] <= '0;
            end
        end else begin
            if (wr_hit) begin
                regs[a3] <= wd3;
            end
            for (int i = 0; i < NREGS; i++) begin
                if (inc_v[i]) begin
                    pend[i] <= pend[i] + CNT_W'(1);
                end else if (dec_v[i]) begin
                    pend[i] <= pend[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        ra[0] = a1;
        ra[1] = a2;
        ra[2] = a3;
    end

    // Busy reflects registered pending state only; write data may be bypassed.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd[p]   = '0;
            busy[p] = 1'b0;
            if (in_range(ra[p])) begin
                rd[p]   = regs[ra[p]];
                busy[p] = (pend[ra[p]] != '0);
                if ((BYPASS != 0) && wre && (a3 == ra[p])) begin
                    rd[p] = wd3;
                end
            end
        end
    end

    assign rd1   = rd[0];
    assign rd2   = rd[1];
    assign rd3   = rd[2];
    assign busy1 = busy[0];
    assign busy2 = busy[1];
    assign busy3 = busy[2];

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a forwarding instance and a non-forwarding
// instance share the same stimulus; expected values are queued per cycle.
module tb_regfile_sb;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int W  = 4 + DW;

    localparam logic [3:0] T_RD1 = 4'd0, T_RD2 = 4'd1, T_RD3 = 4'd2,
                           T_B1 = 4'd3, T_B2 = 4'd4, T_B3 = 4'd5,
                           T_RDY = 4'd6, T_NB_RD1 = 4'd7;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] a1, a2, a3, iss_addr;
    logic [DW-1:0] wd3;
    logic          wre, iss_valid;
    logic [DW-1:0] rd1, rd2, rd3;
    logic          iss_ready, busy1, busy2, busy3;
    logic [DW-1:0] nb_rd1, nb_rd2, nb_rd3;
    logic          nb_iss_ready, nb_busy1, nb_busy2, nb_busy3;

    logic [W-1:0]  exp_q [$];
    logic [W-1:0]  mon_e;
    logic [DW-1:0] mon_act;
    int            checks = 0;
    int            errors = 0;

    regfile_sb #(.DATA_W(DW), .NREGS(12), .ADDR_W(AW), .BYPASS(1), .PEND_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .a3(a3),
        .rd1(rd1), .rd2(rd2), .rd3(rd3), .wre(wre), .wd3(wd3),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .busy1(busy1), .busy2(busy2), .busy3(busy3)
    );

    regfile_sb #(.DATA_W(DW), .NREGS(12), .ADDR_W(AW), .BYPASS(0), .PEND_MAX(3)) dut_nb (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .a3(a3),
        .rd1(nb_rd1), .rd2(nb_rd2), .rd3(nb_rd3), .wre(wre), .wd3(wd3),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(nb_iss_ready),
        .busy1(nb_busy1), .busy2(nb_busy2), .busy3(nb_busy3)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial rst_n = 1'b0;

    // Driver tasks
    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] x1, input logic [AW-1:0] x2,
                         input logic iv, input logic [AW-1:0] ia);
        wre       = w;
        a3        = wa;
        wd3       = wd;
        a1        = x1;
        a2        = x2;
        iss_valid = iv;
        iss_addr  = ia;
    endtask

    task automatic expect_val(input logic [3:0] tag, input logic [DW-1:0] v);
        exp_q.push_back({tag, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] actual(input logic [3:0] tag);
        case (tag)
            T_RD1:    return rd1;
            T_RD2:    return rd2;
            T_RD3:    return rd3;
            T_B1:     return DW'(busy1);
            T_B2:     return DW'(busy2);
            T_B3:     return DW'(busy3);
            T_RDY:    return DW'(iss_ready);
            T_NB_RD1: return nb_rd1;
            default:  return '1;
        endcase
    endfunction

    function automatic string tag_name(input logic [3:0] tag);
        case (tag)
            T_RD1:    return "rd1";
            T_RD2:    return "rd2";
            T_RD3:    return "rd3";
            T_B1:     return "busy1";
            T_B2:     return "busy2";
            T_B3:     return "busy3";
            T_RDY:    return "iss_ready";
            T_NB_RD1: return "nobypass_rd1";
            default:  return "unknown";
        endcase
    endfunction

    // Scoreboard monitor: outputs are sampled mid-cycle on the falling edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_act = actual(mon_e[W-1:DW]);
            checks++;
            if (mon_act !== mon_e[DW-1:0]) begin
                errors++;
                $display("FAIL %s at %0t: got %h, expected %h",
                         tag_name(mon_e[W-1:DW]), $time, mon_act, mon_e[DW-1:0]);
            end
        end
    end

    initial begin
        // Reset with a reservation request held on: it must be discarded
        drive(1'b0, 4'd12, 16'h0000, 4'd0, 4'd11, 1'b1, 4'd0);
        expect_val(T_RD1, 16'h0001);
        expect_val(T_RD2, 16'h000C);
        expect_val(T_RD3, 16'h0000);
        expect_val(T_B1, 16'h0);
        expect_val(T_B3, 16'h0);
        expect_val(T_RDY, 16'h1);
        tick();
        tick();
        rst_n     = 1'b1;
        iss_valid = 1'b0;
        expect_val(T_RD1, 16'h0001);
        expect_val(T_RD2, 16'h000C);
        expect_val(T_RD3, 16'h0000);
        expect_val(T_B1, 16'h0);
        expect_val(T_B2, 16'h0);
        expect_val(T_B3, 16'h0);
        tick();

        // Write with forwarding versus without
        drive(1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd0, 1'b0, 4'd0);
        expect_val(T_RD1, 16'hBEEF);
        expect_val(T_RD3, 16'hBEEF);
        expect_val(T_NB_RD1, 16'h0006);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd5, 4'd0, 1'b0, 4'd0);
        expect_val(T_RD1, 16'hBEEF);
        expect_val(T_NB_RD1, 16'hBEEF);
        tick();

        // Fill register 3 to PEND_MAX
        drive(1'b0, 4'd0, 16'h0000, 4'd3, 4'd0, 1'b1, 4'd3);
        expect_val(T_B1, 16'h0);
        expect_val(T_RDY, 16'h1);
        tick();
        expect_val(T_B1, 16'h1);
        expect_val(T_RDY, 16'h1);
        tick();
        expect_val(T_RDY, 16'h1);
        tick();
        expect_val(T_RDY, 16'h0);
        expect_val(T_B1, 16'h1);
        tick();
        drive(1'b1, 4'd3, 16'h3333, 4'd3, 4'd0, 1'b1, 4'd3);
        expect_val(T_RDY, 16'h1);
        expect_val(T_B3, 16'h1);
        expect_val(T_RD3, 16'h3333);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd3, 4'd0, 1'b1, 4'd3);
        expect_val(T_RDY, 16'h0);
        expect_val(T_RD1, 16'h3333);
        tick();

        // One reservation retired by one write
        drive(1'b0, 4'd0, 16'h0000, 4'd7, 4'd0, 1'b1, 4'd7);
        expect_val(T_B1, 16'h0);
        expect_val(T_RDY, 16'h1);
        tick();
        drive(1'b1, 4'd7, 16'h1234, 4'd7, 4'd0, 1'b0, 4'd0);
        expect_val(T_B1, 16'h1);
        expect_val(T_RD1, 16'h1234);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd7, 4'd0, 1'b0, 4'd0);
        expect_val(T_B1, 16'h0);
        expect_val(T_RD1, 16'h1234);
        tick();

        // Write to an unreserved register must not underflow
        drive(1'b1, 4'd2, 16'hABCD, 4'd0, 4'd2, 1'b0, 4'd0);
        expect_val(T_B2, 16'h0);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd2, 1'b0, 4'd0);
        expect_val(T_RD2, 16'hABCD);
        expect_val(T_B2, 16'h0);
        tick();

        // Out-of-range write, read and reservation
        drive(1'b1, 4'd13, 16'h5555, 4'd13, 4'd0, 1'b1, 4'd14);
        expect_val(T_RD1, 16'h0000);
        expect_val(T_RD3, 16'h0000);
        expect_val(T_B3, 16'h0);
        expect_val(T_RDY, 16'h1);
        tick();

        // Two reservations on register 4, then reset in the middle of a cycle
        drive(1'b0, 4'd0, 16'h0000, 4'd4, 4'd0, 1'b1, 4'd4);
        tick();
        tick();
        drive(1'b0, 4'd0, 16'h0000, 4'd4, 4'd0, 1'b0, 4'd3);
        expect_val(T_B1, 16'h1);
        expect_val(T_RD1, 16'h0005);
        expect_val(T_RDY, 16'h0);
        tick();
        drive(1'b0, 4'd3, 16'h0000, 4'd4, 4'd5, 1'b1, 4'd3);
        #2;
        rst_n = 1'b0;
        expect_val(T_B1, 16'h0);
        expect_val(T_RD1, 16'h0005);
        expect_val(T_RD2, 16'h0006);
        expect_val(T_RD3, 16'h0004);
        expect_val(T_RDY, 16'h1);
        tick();
        rst_n     = 1'b1;
        iss_valid = 1'b0;
        expect_val(T_B1, 16'h0);
        expect_val(T_B3, 16'h0);
        expect_val(T_RD2, 16'h0006);
        expect_val(T_RDY, 16'h1);
        tick();
        tick();

        // Final report
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, register data width in bits.
REQ-002 SHALL provide parameter NREGS, default 12, number of architectural registers (2..16).
REQ-003 SHALL provide parameter ADDR_W, default 4, register address width; NREGS <= 2**ADDR_W.
REQ-004 SHALL provide parameter BYPASS, default 1, 1 = write-to-read forwarding enabled, 0 = disabled.
REQ-005 SHALL provide parameter PEND_MAX, default 3, maximum outstanding writers per register (1..7).
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL provide clk  input  1  rising-edge clock.
REQ-008 SHALL provide rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL provide a1, a2, a3  input  ADDR_W  read-port addresses; a3 is also the write address.
REQ-010 SHALL provide rd1, rd2, rd3  output  DATA_W  combinational read data.
REQ-011 SHALL provide wre  input  1  write enable for wd3 into register a3.
REQ-012 SHALL provide wd3  input  DATA_W  write data.
REQ-013 SHALL provide iss_valid  input  1  request to reserve register iss_addr for a future write.
REQ-014 SHALL provide iss_addr  input  ADDR_W  destination register being reserved.
REQ-015 SHALL provide iss_ready  output  1  reservation accepted this cycle when high with iss_valid.
REQ-016 SHALL provide busy1, busy2, busy3  output  1  register at a1/a2/a3 has an outstanding writer.

Function
REQ-017 SHALL hold NREGS data registers plus one pending counter per register, width clog2(PEND_MAX+1).
REQ-018 SHALL write wd3 into register a3 on rising clk when wre=1 and a3 < NREGS; a write to a3 >= NREGS is discarded.
REQ-019 SHALL drive rdN = register[aN] combinationally; aN >= NREGS reads all zeros.
REQ-020 SHALL, when BYPASS=1 and wre=1 and a3=aN < NREGS, drive rdN = wd3 in the same cycle (rd3 therefore equals wd3 during a write).
REQ-021 SHALL drive iss_ready = 1 when pending[iss_addr] < PEND_MAX or (wre=1 and a3=iss_addr), and 1 for iss_addr >= NREGS (reservation ignored), otherwise 0; iss_ready SHALL NOT depend on iss_valid.
REQ-022 SHALL increment pending[iss_addr] on a clock edge with iss_valid & iss_ready and no write to the same register.
REQ-023 SHALL decrement pending[a3] on a clock edge with wre=1 and pending[a3] > 0 and no accepted reservation of the same register.
REQ-024 SHALL leave pending unchanged when an accepted reservation and a write target the same register in one cycle.
REQ-025 SHALL leave pending[a3] at 0 on a write to an unreserved register (no underflow); the data write still occurs.
REQ-026 SHALL drive busyN = (pending[aN] != 0) from registered state only, no bypass; aN >= NREGS gives busyN = 0.
REQ-027 SHALL never let a pending counter exceed PEND_MAX or wrap.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously set register i to value i+1 (zero-extended to DATA_W) and every pending counter to 0.
REQ-029 SHALL, during and after reset until first update, present busy1..3 = 0, iss_ready = 1, rdN = aN+1 for aN < NREGS.
REQ-030 SHALL discard any write or reservation coinciding with rst_n=0; operation resumes on the first rising clk with rst_n=1.

Verification
REQ-031 Reset then a1=0, a2=11, a3=12 -> rd1=16'h0001, rd2=16'h000C, rd3=16'h0000, all busy=0.
REQ-032 wre=1, a3=5, wd3=16'hBEEF, a1=5, BYPASS=1 -> rd1=16'hBEEF same cycle, register 5 holds 16'hBEEF after edge; with BYPASS=0 rd1=16'h0006 that cycle.
REQ-033 Reserve register 3 three times (PEND_MAX=3) -> busy on a1=3, fourth iss_valid sees iss_ready=0, pending stays 3; then wre on 3 with iss_valid on 3 -> iss_ready=1, pending stays 3.
REQ-034 Reserve register 7 once, then wre to 7 with wd3=16'h1234 -> busy1 (a1=7) drops to 0 after edge, rd1=16'h1234.
REQ-035 wre to unreserved register 2 -> pending[2] stays 0, busy=0, data updated.
REQ-036 Reserve register 4 twice, assert rst_n=0 mid-cycle -> busy drops to 0 immediately, register 4 reads 16'h0005, iss_ready=1.
